// File: rtl/ct_decrypt_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// ct_decrypt_seq_pkg : shared sizes, moduli and types for the decryptor
// rev 1.0
// ----------------------------------------------------------------------
package ct_decrypt_seq_pkg;

  localparam int N_SLOTS_L = 8;
  localparam int W_BITS    = 16;
  localparam int Q_MOD     = 7710;
  localparam int T_MOD     = 257;
  localparam int DELTA     = 30;
  localparam int IDX_W     = $clog2(N_SLOTS_L);

  typedef logic [N_SLOTS_L-1:0][W_BITS-1:0] vec_t;

  typedef struct packed {
    vec_t a;
    vec_t b;
  } CT_t;

  typedef vec_t PT_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ct_decrypt_seq_slot_decrypt.sv
`default_nettype none
// ----------------------------------------------------------------------
// slot_decrypt : combinational single-slot decode m = round(((B-A*s) mod Q)/DELTA) mod T
// rev 1.0
// ----------------------------------------------------------------------
module slot_decrypt
  import ct_decrypt_seq_pkg::*;
(
  input  logic [W_BITS-1:0] a_i,
  input  logic [W_BITS-1:0] b_i,
  input  logic [W_BITS-1:0] s_i,
  output logic [W_BITS-1:0] m_o
);

  localparam int DW = 2 * W_BITS;
  localparam logic [DW-1:0] Q_W    = DW'(Q_MOD);
  localparam logic [DW-1:0] T_W    = DW'(T_MOD);
  localparam logic [DW-1:0] DLT_W  = DW'(DELTA);
  localparam logic [DW-1:0] HALF_W = DW'(DELTA / 2);

  logic [DW-1:0] w_prod;
  logic [DW-1:0] w_p;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_diff;
  logic [DW-1:0] w_d;
  logic [DW-1:0] w_round;

  always_comb begin
    w_prod  = {{W_BITS{1'b0}}, a_i} * {{W_BITS{1'b0}}, s_i};
    w_p     = w_prod % Q_W;
    w_b     = {{W_BITS{1'b0}}, b_i} % Q_W;
    // Adding Q before subtracting keeps the difference non-negative.
    w_diff  = w_b + Q_W - w_p;
    w_d     = (w_diff >= Q_W) ? (w_diff - Q_W) : w_diff;
    w_round = (w_d + HALF_W) / DLT_W;
    // Only the top DELTA/2 residues reach T, so one conditional subtract suffices.
    m_o     = W_BITS'((w_round >= T_W) ? (w_round - T_W) : w_round);
  end

endmodule
`default_nettype wire

// File: rtl/ct_decrypt_seq.sv
`default_nettype none
// ----------------------------------------------------------------------
// ct_decrypt_seq : slot-serial ciphertext decryptor with valid/ready in and out
// rev 1.0
// ----------------------------------------------------------------------
module ct_decrypt_seq
  import ct_decrypt_seq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  CT_t  in_ct,
  input  vec_t in_sk,
  output logic out_valid,
  input  logic out_ready,
  output PT_t  out_pt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS_L - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  vec_t              a_q, a_d;
  vec_t              b_q, b_d;
  vec_t              s_q, s_d;
  PT_t               pt_q, pt_d;
  logic [W_BITS-1:0] w_m;

  slot_decrypt u_slot (
    .a_i (a_q[idx_q]),
    .b_i (b_q[idx_q]),
    .s_i (s_q[idx_q]),
    .m_o (w_m)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    pt_d      = pt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_ct.a;
          b_d     = in_ct.b;
          s_d     = in_sk;
          idx_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        pt_d[idx_q] = w_m;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      pt_q    <= pt_d;
    end
  end

  assign out_pt = pt_q;

endmodule
`default_nettype wire

// File: tb/tb_ct_decrypt_seq.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_ct_decrypt_seq : scoreboard bench for the slot-serial decryptor
// rev 1.0
// ----------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ct_decrypt_seq;
  import ct_decrypt_seq_pkg::*;

  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready;
  logic out_valid;
  CT_t  in_ct     = '0;
  vec_t in_sk     = '0;
  PT_t  out_pt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  PT_t sb[$];
  PT_t obs[$];
  int  obs_cyc[$];

  ct_decrypt_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ct     (in_ct),
    .in_sk     (in_sk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pt    (out_pt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Each negedge with valid&&ready precedes exactly one output transfer.
  always @(negedge clock) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      obs.push_back(out_pt);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic PT_t model(input CT_t ct, input vec_t sk);
    PT_t r;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      longint a = longint'(ct.a[i]);
      longint b = longint'(ct.b[i]);
      longint s = longint'(sk[i]);
      longint p = (a * s) % Q_MOD;
      longint d = (b % Q_MOD) - p;
      if (d < 0) d = d + Q_MOD;
      r[i] = W_BITS'(((d + DELTA / 2) / DELTA) % T_MOD);
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input CT_t ct, input vec_t sk);
    in_ct    = ct;
    in_sk    = sk;
    in_valid = 1'b1;
    sb.push_back(model(ct, sk));
  endtask

  task automatic wait_accept(output int acc, output bit ok);
    int n;
    n   = 0;
    ok  = 1'b0;
    acc = -1;
    while (!ok && n < 200) begin
      if (in_valid && in_ready) begin
        tick(1);
        acc = cyc;
        ok  = 1'b1;
      end else begin
        tick(1);
        n++;
      end
    end
  endtask

  task automatic wait_obs(input int cnt, output bit ok);
    int n;
    n = 0;
    while (obs.size() < cnt && n < 200) begin
      tick(1);
      n++;
    end
    ok = (obs.size() >= cnt);
  endtask

  task automatic test_reset;
    CT_t ct;
    vec_t sk;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      ct.a[i] = W_BITS'(i + 3);
      ct.b[i] = W_BITS'(100 * i);
      sk[i]   = W_BITS'(i);
    end
    reset    = 1'b1;
    in_ct    = ct;
    in_sk    = sk;
    in_valid = 1'b1;
    tick(3);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++;
    if (out_pt !== '0) begin bad++; $display("FAIL reset_out_pt got=%h exp=0", out_pt); end
    reset    = 1'b0;
    in_valid = 1'b0;
    tick(3);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_no_capture in_ready got=%b exp=1", in_ready); end
    total++;
    if (obs.size() != 0) begin bad++; $display("FAIL reset_no_output got=%0d exp=0", obs.size()); end
  endtask

  task automatic test_basic;
    CT_t ct;
    vec_t sk;
    PT_t lit, got, exp;
    int acc, vc;
    bit ok;
    int avals[8] = '{1429, 4717, 6311, 3279, 7215, 6215, 6931, 973};
    for (int i = 0; i < N_SLOTS_L; i++) begin
      ct.a[i] = W_BITS'(avals[i]);
      ct.b[i] = W_BITS'(30 * (i + 1));
      sk[i]   = '0;
      lit[i]  = W_BITS'(i + 1);
    end
    out_ready = 1'b1;
    drive(ct, sk);
    wait_accept(acc, ok);
    in_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL basic_accept timeout got=0 exp=1"); end
    wait_obs(1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_output timeout got=0 exp=1");
    end else begin
      got = obs.pop_front();
      vc  = obs_cyc.pop_front();
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL basic_pt got=%h exp=%h", got, exp); end
      total++;
      if (got !== lit) begin bad++; $display("FAIL basic_literal got=%h exp=%h", got, lit); end
      total++;
      if (vc - acc != N_SLOTS_L) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", vc - acc, N_SLOTS_L); end
    end
  endtask

  task automatic test_round;
    CT_t ct;
    vec_t sk;
    PT_t got, exp;
    int acc;
    bit ok;
    int bvals[5] = '{1579, 1593, 1594, 1595, 1430};
    int mvals[5] = '{5, 5, 6, 6, 0};
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N_SLOTS_L; i++) begin
        ct.a[i] = W_BITS'(100 * i + c);
        ct.b[i] = W_BITS'(1000 * i + 7 * c);
        sk[i]   = W_BITS'(i);
      end
      ct.a[0] = W_BITS'(1429);
      ct.b[0] = W_BITS'(bvals[c]);
      sk[0]   = W_BITS'(1);
      drive(ct, sk);
      wait_accept(acc, ok);
      in_valid = 1'b0;
      wait_obs(1, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL round_output case=%0d timeout got=0 exp=1", c);
      end else begin
        got = obs.pop_front();
        void'(obs_cyc.pop_front());
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL round_pt case=%0d got=%h exp=%h", c, got, exp); end
        total++;
        if (got[0] !== W_BITS'(mvals[c])) begin
          bad++; $display("FAIL round_slot0 case=%0d got=%0d exp=%0d", c, got[0], mvals[c]);
        end
      end
    end
  endtask

  task automatic test_wrap;
    CT_t ct;
    vec_t sk;
    PT_t got, exp;
    int acc;
    bit ok;
    ct = '0;
    sk = '0;
    ct.a[0] = 16'd1;     sk[0] = 16'd1;     ct.b[0] = 16'd0;
    ct.a[1] = 16'd5;     sk[1] = 16'd0;     ct.b[1] = 16'd7694;
    ct.a[2] = 16'd9;     sk[2] = 16'd0;     ct.b[2] = 16'd7695;
    ct.a[3] = 16'hFFFF;  sk[3] = 16'hFFFF;  ct.b[3] = 16'd100;
    ct.a[4] = 16'd7710;  sk[4] = 16'd5;     ct.b[4] = 16'hFFFF;
    ct.a[5] = 16'd12345; sk[5] = 16'd7711;  ct.b[5] = 16'd7709;
    ct.a[6] = 16'd2;     sk[6] = 16'd3;     ct.b[6] = 16'd20;
    ct.a[7] = 16'd7709;  sk[7] = 16'd7709;  ct.b[7] = 16'd15;
    out_ready = 1'b1;
    drive(ct, sk);
    wait_accept(acc, ok);
    in_valid = 1'b0;
    wait_obs(1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wrap_output timeout got=0 exp=1");
    end else begin
      got = obs.pop_front();
      void'(obs_cyc.pop_front());
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL wrap_pt got=%h exp=%h", got, exp); end
      total++;
      if (got[0] !== 16'd0) begin bad++; $display("FAIL wrap_neg got=%0d exp=0", got[0]); end
      total++;
      if (got[1] !== 16'd256) begin bad++; $display("FAIL wrap_top got=%0d exp=256", got[1]); end
      total++;
      if (got[2] !== 16'd0) begin bad++; $display("FAIL wrap_T got=%0d exp=0", got[2]); end
    end
  endtask

  task automatic test_backpressure;
    CT_t ct1, ct2;
    vec_t sk1, sk2;
    PT_t held, got, exp;
    int acc, acc2, hs, n;
    bit ok;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      ct1.a[i] = W_BITS'(333 * i + 11);
      ct1.b[i] = W_BITS'(977 * i + 5);
      sk1[i]   = W_BITS'(2 * i + 1);
      ct2.a[i] = W_BITS'(1201 * i + 3);
      ct2.b[i] = W_BITS'(450 * i + 900);
      sk2[i]   = W_BITS'(7 - i);
    end
    out_ready = 1'b0;
    drive(ct1, sk1);
    wait_accept(acc, ok);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_done timeout got=%b exp=1", out_valid); end
    held = out_pt;
    drive(ct2, sk2);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", k, out_valid); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
      total++;
      if (out_pt !== held) begin bad++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", k, out_pt, held); end
    end
    out_ready = 1'b1;
    wait_accept(acc2, ok);
    in_valid = 1'b0;
    wait_obs(2, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_output timeout got=%0d exp=2", obs.size());
    end else begin
      got = obs.pop_front();
      hs  = obs_cyc.pop_front();
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL bp_first_pt got=%h exp=%h", got, exp); end
      total++;
      if (acc2 != hs + 2) begin bad++; $display("FAIL bp_second_accept got=%0d exp=%0d", acc2, hs + 2); end
      got = obs.pop_front();
      void'(obs_cyc.pop_front());
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL bp_second_pt got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_back_to_back;
    CT_t ct1, ct2;
    vec_t sk1, sk2;
    PT_t got, exp;
    int acc1, acc2;
    bit ok1, ok2, ok;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      ct1.a[i] = W_BITS'(71 * i + 2);
      ct1.b[i] = W_BITS'(3000 + 511 * i);
      sk1[i]   = W_BITS'(13 * i);
      ct2.a[i] = W_BITS'(60000 - 999 * i);
      ct2.b[i] = W_BITS'(40000 + 17 * i);
      sk2[i]   = W_BITS'(50000 + i);
    end
    out_ready = 1'b1;
    drive(ct1, sk1);
    wait_accept(acc1, ok1);
    drive(ct2, sk2);
    wait_accept(acc2, ok2);
    in_valid = 1'b0;
    total++;
    if (!(ok1 && ok2)) begin bad++; $display("FAIL b2b_accept timeout got=%b%b exp=11", ok1, ok2); end
    total++;
    if (acc2 - acc1 != N_SLOTS_L + 2) begin
      bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc2 - acc1, N_SLOTS_L + 2);
    end
    wait_obs(2, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_output timeout got=%0d exp=2", obs.size());
    end else begin
      for (int j = 0; j < 2; j++) begin
        got = obs.pop_front();
        void'(obs_cyc.pop_front());
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL b2b_pt idx=%0d got=%h exp=%h", j, got, exp); end
      end
    end
  endtask

  task automatic test_reset_mid;
    CT_t ct1, ct2;
    vec_t sk1, sk2;
    PT_t got, exp;
    int acc;
    bit ok;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      ct1.a[i] = W_BITS'(5000 + i);
      ct1.b[i] = W_BITS'(6000 + 3 * i);
      sk1[i]   = W_BITS'(9 + i);
      ct2.a[i] = W_BITS'(i);
      ct2.b[i] = W_BITS'(30 * (8 - i));
      sk2[i]   = W_BITS'(0);
    end
    out_ready = 1'b1;
    drive(ct1, sk1);
    wait_accept(acc, ok);
    in_valid = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    void'(sb.pop_back());
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    total++;
    if (out_pt !== '0) begin bad++; $display("FAIL rstmid_pt got=%h exp=0", out_pt); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    tick(12);
    total++;
    if (obs.size() != 0) begin bad++; $display("FAIL rstmid_no_output got=%0d exp=0", obs.size()); end
    drive(ct2, sk2);
    wait_accept(acc, ok);
    in_valid = 1'b0;
    wait_obs(1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rstmid_fresh timeout got=0 exp=1");
    end else begin
      got = obs.pop_front();
      void'(obs_cyc.pop_front());
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL rstmid_fresh_pt got=%h exp=%h", got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
